// File: rtl/cache_pkg.sv
// cache_pkg: shared constants, FSM state type and address helper for the
// line-fill sequencer.
//   WORD_SIZE      bits per word / memory beat
//   WORDS_PER_LINE words per cache line (power of two, >= 2)
//   LINE_BITS      word-index width within a line
//   BYTE_BITS      byte-offset bits within a word
package cache_pkg;

  localparam int unsigned WORD_SIZE      = 32;
  localparam int unsigned WORDS_PER_LINE = 8;
  localparam int unsigned LINE_BITS      = $clog2(WORDS_PER_LINE);
  localparam int unsigned BYTE_BITS      = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } fill_state_t;

  // base: line-aligned byte address (offset bits already zero)
  // index: word index within the line, zero-extended
  function automatic logic [31:0] line_word_addr(input logic [31:0] base,
                                                 input logic [31:0] index);
    return base | (index << BYTE_BITS);
  endfunction

endpackage

// File: rtl/line_fill_ctrl_if.sv
// line_fill_ctrl_if: word-wide memory request bus between the line-fill
// sequencer (master) and main memory (slave).
//   mem_addr_o   word-aligned byte address
//   mem_wdata_o  write data
//   mem_rd_o     read request, held until mem_ack_i
//   mem_wr_o     write request, held until mem_ack_i
//   mem_ack_i    completes the current beat
//   mem_rdata_i  read data, valid with mem_ack_i
interface line_fill_ctrl_if #(
  parameter int unsigned WORD_SIZE = cache_pkg::WORD_SIZE
);

  logic [31:0]          mem_addr_o;
  logic [WORD_SIZE-1:0] mem_wdata_o;
  logic                 mem_rd_o;
  logic                 mem_wr_o;
  logic                 mem_ack_i;
  logic [WORD_SIZE-1:0] mem_rdata_i;

  modport master (
    output mem_addr_o, mem_wdata_o, mem_rd_o, mem_wr_o,
    input  mem_ack_i, mem_rdata_i
  );

  modport slave (
    input  mem_addr_o, mem_wdata_o, mem_rd_o, mem_wr_o,
    output mem_ack_i, mem_rdata_i
  );

endinterface

// File: rtl/line_beat_ctr.sv
// line_beat_ctr: beat counter for one line-transfer phase.
//   clk      clock, rising edge
//   clr      asynchronous active-low reset
//   clear_i  synchronous return to beat 0 (phase entry), wins over inc_i
//   inc_i    advance one beat
//   start_i  word index of beat 0
//   beat_o   beats completed in this phase
//   idx_o    (start_i + beat_o) mod line length
//   last_o   current beat is the final one of the line
module line_beat_ctr #(
  parameter int unsigned LINE_BITS = 3
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 clear_i,
  input  logic                 inc_i,
  input  logic [LINE_BITS-1:0] start_i,
  output logic [LINE_BITS-1:0] beat_o,
  output logic [LINE_BITS-1:0] idx_o,
  output logic                 last_o
);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      beat_o <= '0;
    end else if (clear_i) begin
      beat_o <= '0;
    end else if (inc_i) begin
      beat_o <= beat_o + 1'b1;
    end
  end

  // Natural LINE_BITS overflow gives the wrap past the end of the line.
  assign idx_o  = beat_o + start_i;
  assign last_o = &beat_o;

endmodule

// File: rtl/line_fill_ctrl.sv
// line_fill_ctrl: miss-handling sequencer between the cache controller and
// main memory. On a miss it optionally writes back the dirty victim line, then
// fetches the missing line one word per memory handshake, driving the line
// adapter controls, and pulses done_o so the controller can retry.
//   clk            clock, rising edge
//   clr            asynchronous active-low reset
//   miss_i         miss request (sampled in IDLE only)
//   dirty_i        victim dirty, sampled with miss_i
//   miss_addr_i    missing byte address, sampled with miss_i
//   victim_addr_i  victim line address, sampled with miss_i
//   wb_data_i      victim word at wb_idx_o (combinational from data array)
//   wb_idx_o       victim word index under write-back
//   mem            memory bus (master modport)
//   fill_clr_o     adapter counter clear
//   fill_next_o    adapter counter advance
//   fill_we_o      adapter word write
//   fill_data_o    registered fill word
//   crit_o         critical word delivered
//   busy_o         high in any non-IDLE state
//   done_o         one-cycle completion pulse
// Optional feature macro: FILL_CRITICAL_FIRST_EN (fill starts at the missing
// word and wraps; crit_o marks the first delivered word).
module line_fill_ctrl #(
  parameter  int unsigned WORD_SIZE      = cache_pkg::WORD_SIZE,
  parameter  int unsigned WORDS_PER_LINE = cache_pkg::WORDS_PER_LINE,
  localparam int unsigned LINE_BITS      = $clog2(WORDS_PER_LINE),
  localparam int unsigned BYTE_BITS      = cache_pkg::BYTE_BITS
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  miss_i,
  input  logic                  dirty_i,
  input  logic [31:0]           miss_addr_i,
  input  logic [31:0]           victim_addr_i,
  input  logic [WORD_SIZE-1:0]  wb_data_i,
  output logic [LINE_BITS-1:0]  wb_idx_o,
  line_fill_ctrl_if.master      mem,
  output logic                  fill_clr_o,
  output logic                  fill_next_o,
  output logic                  fill_we_o,
  output logic [WORD_SIZE-1:0]  fill_data_o,
  output logic                  crit_o,
  output logic                  busy_o,
  output logic                  done_o
);

  import cache_pkg::*;

  localparam int unsigned OFF_BITS = LINE_BITS + BYTE_BITS;

  fill_state_t          state_q, state_d;
  logic [31:0]          miss_line_q, victim_line_q;
  logic                 fill_we_q;
  logic [LINE_BITS-1:0] fill_start;
  logic [LINE_BITS-1:0] start, beat, idx;
  logic                 last;
  logic                 accept, beat_ack, phase_end;
  logic [31:0]          idx_ext;
  logic                 unused_bits;

  assign accept    = (state_q == IDLE) && miss_i;
  assign beat_ack  = mem.mem_ack_i && ((state_q == WB) || (state_q == FILL));
  assign phase_end = beat_ack && last;

  // Write-back always starts at word 0; only the fill may be rotated.
  assign start = (state_q == FILL) ? fill_start : '0;

  line_beat_ctr #(
    .LINE_BITS (LINE_BITS)
  ) u_beat (
    .clk     (clk),
    .clr     (clr),
    .clear_i (accept || phase_end),
    .inc_i   (beat_ack),
    .start_i (start),
    .beat_o  (beat),
    .idx_o   (idx),
    .last_o  (last)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (miss_i) state_d = dirty_i ? WB : FILL;
      WB:      if (phase_end) state_d = FILL;
      FILL:    if (phase_end) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q       <= IDLE;
      miss_line_q   <= '0;
      victim_line_q <= '0;
      fill_clr_o    <= 1'b0;
      fill_we_q     <= 1'b0;
      fill_data_o   <= '0;
    end else begin
      state_q    <= state_d;
      fill_clr_o <= accept;
      fill_we_q  <= beat_ack && (state_q == FILL);
      if (accept) begin
        miss_line_q   <= {miss_addr_i[31:OFF_BITS], {OFF_BITS{1'b0}}};
        victim_line_q <= {victim_addr_i[31:OFF_BITS], {OFF_BITS{1'b0}}};
      end
      if (beat_ack && (state_q == FILL)) begin
        fill_data_o <= mem.mem_rdata_i;
      end
    end
  end

`ifdef FILL_CRITICAL_FIRST_EN
  logic crit_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      fill_start <= '0;
      crit_q     <= 1'b0;
    end else begin
      if (accept) begin
        fill_start <= miss_addr_i[OFF_BITS-1:BYTE_BITS];
      end
      crit_q <= beat_ack && (state_q == FILL) && (beat == '0);
    end
  end

  assign crit_o = crit_q;
`else
  assign fill_start = '0;
  assign crit_o     = 1'b0;
`endif

  assign idx_ext = {{(32-LINE_BITS){1'b0}}, idx};

  // Bus outputs decode from the registered state, so rd/wr swap in one edge
  // at the WB->FILL boundary and everything is zero while in reset.
  always_comb begin
    mem.mem_addr_o  = '0;
    mem.mem_wdata_o = '0;
    mem.mem_rd_o    = 1'b0;
    mem.mem_wr_o    = 1'b0;
    wb_idx_o        = '0;
    case (state_q)
      WB: begin
        mem.mem_wr_o    = 1'b1;
        mem.mem_addr_o  = line_word_addr(victim_line_q, idx_ext);
        mem.mem_wdata_o = wb_data_i;
        wb_idx_o        = idx;
      end
      FILL: begin
        mem.mem_rd_o   = 1'b1;
        mem.mem_addr_o = line_word_addr(miss_line_q, idx_ext);
      end
      default: ;
    endcase
  end

  assign fill_we_o   = fill_we_q;
  assign fill_next_o = fill_we_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);

  assign unused_bits = ^{victim_addr_i[OFF_BITS-1:0], miss_addr_i[OFF_BITS-1:0], beat};

endmodule

// File: tb/tb_line_fill_ctrl.sv
module tb_line_fill_ctrl;

`ifdef FILL_CRITICAL_FIRST_EN
  localparam bit CRIT = 1'b1;
`else
  localparam bit CRIT = 1'b0;
`endif

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  idx;
  } mem_exp_t;

  typedef struct {
    logic [31:0] data;
    logic        crit;
  } fill_exp_t;

  logic        clk;
  logic        clr;
  logic        miss_i;
  logic        dirty_i;
  logic [31:0] miss_addr_i;
  logic [31:0] victim_addr_i;
  logic [31:0] wb_data_i;
  logic [2:0]  wb_idx_o;
  logic        fill_clr_o, fill_next_o, fill_we_o, crit_o, busy_o, done_o;
  logic [31:0] fill_data_o;

  line_fill_ctrl_if mem_if ();

  line_fill_ctrl dut (
    .clk           (clk),
    .clr           (clr),
    .miss_i        (miss_i),
    .dirty_i       (dirty_i),
    .miss_addr_i   (miss_addr_i),
    .victim_addr_i (victim_addr_i),
    .wb_data_i     (wb_data_i),
    .wb_idx_o      (wb_idx_o),
    .mem           (mem_if),
    .fill_clr_o    (fill_clr_o),
    .fill_next_o   (fill_next_o),
    .fill_we_o     (fill_we_o),
    .fill_data_o   (fill_data_o),
    .crit_o        (crit_o),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mem_exp_t  exp_mem[$];
  fill_exp_t exp_fill[$];
  int exp_done = 0;
  int exp_clr  = 0;
  int done_cnt = 0;
  int fill_cnt = 0;
  int done_cyc = 0;
  bit both_seen = 1'b0;

  // Memory model: sees the request just after the edge, so a zero-wait ack
  // lands in the same cycle the request rises.
  logic model_ack = 1'b0;
  logic force_ack = 1'b0;
  bit   rand_mode = 1'b0;
  bit   pending   = 1'b0;
  int   wait_left = 0;

  assign mem_if.mem_ack_i   = model_ack | force_ack;
  assign mem_if.mem_rdata_i = mem_if.mem_addr_o ^ 32'h5A5A_0000;
  assign wb_data_i          = 32'hB0B0_0000 + {29'b0, wb_idx_o};

  always begin
    @(posedge clk);
    #1;
    if (!clr || !(mem_if.mem_rd_o || mem_if.mem_wr_o)) begin
      model_ack = 1'b0;
      pending   = 1'b0;
    end else begin
      if (!pending) begin
        wait_left = rand_mode ? int'($urandom_range(0, 3)) : 0;
        pending   = 1'b1;
      end
      if (wait_left == 0) begin
        model_ack = 1'b1;
        pending   = 1'b0;
      end else begin
        model_ack = 1'b0;
        wait_left--;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a beat or pulse.
  always @(negedge clk) begin
    mem_exp_t  m;
    fill_exp_t f;
    if (clr) begin
      if (mem_if.mem_rd_o && mem_if.mem_wr_o) both_seen = 1'b1;
      if ((mem_if.mem_rd_o || mem_if.mem_wr_o) && mem_if.mem_ack_i) begin
        total++;
        if (exp_mem.size() == 0) begin
          bad++;
          $display("FAIL mem_beat: unexpected beat wr=%0b addr=%h", mem_if.mem_wr_o, mem_if.mem_addr_o);
        end else begin
          m = exp_mem.pop_front();
          if (mem_if.mem_wr_o !== m.wr || mem_if.mem_addr_o !== m.addr ||
              (m.wr && (mem_if.mem_wdata_o !== m.wdata || wb_idx_o !== m.idx))) begin
            bad++;
            $display("FAIL mem_beat: got wr=%0b addr=%h wdata=%h idx=%0d, want wr=%0b addr=%h wdata=%h idx=%0d",
                     mem_if.mem_wr_o, mem_if.mem_addr_o, mem_if.mem_wdata_o, wb_idx_o,
                     m.wr, m.addr, m.wdata, m.idx);
          end
        end
      end
      if (fill_we_o) begin
        total++;
        fill_cnt++;
        if (exp_fill.size() == 0) begin
          bad++;
          $display("FAIL fill_we: unexpected pulse data=%h", fill_data_o);
        end else begin
          f = exp_fill.pop_front();
          if (fill_data_o !== f.data || crit_o !== f.crit || fill_next_o !== 1'b1) begin
            bad++;
            $display("FAIL fill_we: got data=%h crit=%0b next=%0b, want data=%h crit=%0b next=1",
                     fill_data_o, crit_o, fill_next_o, f.data, f.crit);
          end
        end
      end else if (crit_o || fill_next_o) begin
        total++;
        bad++;
        $display("FAIL fill_ctl: crit=%0b next=%0b without fill_we, want 0", crit_o, fill_next_o);
      end
      if (fill_clr_o) begin
        total++;
        if (exp_clr == 0) begin
          bad++;
          $display("FAIL fill_clr: unexpected pulse, want none");
        end else exp_clr--;
      end
      if (done_o) begin
        total++;
        done_cnt++;
        done_cyc = cyc;
        if (exp_done == 0) begin
          bad++;
          $display("FAIL done: unexpected pulse, want none");
        end else exp_done--;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  function automatic logic [31:0] word_addr(input logic [31:0] a, input int unsigned i);
    return (a & 32'hFFFF_FFE0) | ((i % 8) << 2);
  endfunction

  task automatic push_miss(input logic [31:0] maddr, input logic [31:0] vaddr, input logic dirty);
    mem_exp_t    m;
    fill_exp_t   f;
    int unsigned st;
    st = CRIT ? ((maddr >> 2) & 7) : 0;
    if (dirty) begin
      for (int unsigned i = 0; i < 8; i++) begin
        m.wr = 1'b1; m.addr = word_addr(vaddr, i);
        m.wdata = 32'hB0B0_0000 + i; m.idx = 3'(i);
        exp_mem.push_back(m);
      end
    end
    for (int unsigned i = 0; i < 8; i++) begin
      m.wr = 1'b0; m.addr = word_addr(maddr, st + i); m.wdata = '0; m.idx = '0;
      exp_mem.push_back(m);
      f.data = m.addr ^ 32'h5A5A_0000;
      f.crit = CRIT && (i == 0);
      exp_fill.push_back(f);
    end
    exp_done++;
    exp_clr++;
  endtask

  task automatic do_miss(input logic [31:0] maddr, input logic [31:0] vaddr, input logic dirty,
                         input bit glitch, input bit check_lat);
    int d0;
    int miss_cyc;
    push_miss(maddr, vaddr, dirty);
    d0 = done_cnt;
    @(negedge clk);
    miss_i = 1'b1; dirty_i = dirty; miss_addr_i = maddr; victim_addr_i = vaddr;
    miss_cyc = cyc;
    @(negedge clk);
    miss_i = 1'b0;
    check("first_req", {62'b0, mem_if.mem_wr_o, mem_if.mem_rd_o}, {62'b0, dirty, !dirty});
    if (glitch) begin
      repeat (3) @(negedge clk);
      miss_i = 1'b1; dirty_i = 1'b1; miss_addr_i = 32'hFFFF_0040; victim_addr_i = 32'h4000_0000;
      @(negedge clk);
      miss_i = 1'b0;
    end
    for (int k = 0; k < 400 && done_cnt == d0; k++) @(negedge clk);
    check("done_seen", 64'(done_cnt - d0), 64'd1);
    if (check_lat) check("done_latency", 64'(done_cyc - miss_cyc), 64'd9);
    repeat (3) @(negedge clk);
    check("mem_queue_empty", 64'(exp_mem.size()), 64'd0);
    check("fill_queue_empty", 64'(exp_fill.size()), 64'd0);
    check("busy_after_done", {63'b0, busy_o}, 64'd0);
  endtask

  initial begin
    int f0, d0;
    clr = 1'b0; miss_i = 1'b0; dirty_i = 1'b0; miss_addr_i = '0; victim_addr_i = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {busy_o, done_o, fill_we_o, fill_next_o, fill_clr_o, crit_o,
                            mem_if.mem_rd_o, mem_if.mem_wr_o, wb_idx_o, mem_if.mem_addr_o[15:0],
                            fill_data_o[15:0]}, 64'd0);
    clr = 1'b1;

    // Clean miss, zero-wait memory
    do_miss(32'h0000_1234, 32'h0, 1'b0, 1'b0, 1'b1);
    // Dirty miss: write-back then fill
    do_miss(32'h0000_1234, 32'h0000_8000, 1'b1, 1'b0, 1'b0);
    // Random 0-3 cycle ack delays
    rand_mode = 1'b1;
    do_miss(32'h0000_1234, 32'h0000_8000, 1'b1, 1'b0, 1'b0);
    do_miss(32'h0000_5678, 32'h0, 1'b0, 1'b0, 1'b0);
    rand_mode = 1'b0;
    // miss_i pulsed mid-fill is ignored
    do_miss(32'h0000_1234, 32'h0, 1'b0, 1'b1, 1'b0);

    // Spurious ack in IDLE
    @(negedge clk);
    force_ack = 1'b1;
    repeat (3) @(negedge clk);
    force_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_spurious_ack", {61'b0, busy_o, mem_if.mem_rd_o, mem_if.mem_wr_o}, 64'd0);

    // Reset after 3 fill beats, then a fresh miss
    push_miss(32'h0000_1234, 32'h0, 1'b0);
    f0 = fill_cnt;
    d0 = done_cnt;
    @(negedge clk);
    miss_i = 1'b1; dirty_i = 1'b0; miss_addr_i = 32'h0000_1234;
    @(negedge clk);
    miss_i = 1'b0;
    for (int k = 0; k < 200 && fill_cnt < f0 + 3; k++) begin
      @(posedge clk);
      #2;
    end
    check("fill_beats_before_abort", 64'(fill_cnt - f0), 64'd3);
    clr = 1'b0;
    #1;
    check("async_reset_outputs", {busy_o, done_o, fill_we_o, fill_next_o, fill_clr_o, crit_o,
                                  mem_if.mem_rd_o, mem_if.mem_wr_o, wb_idx_o,
                                  mem_if.mem_addr_o[15:0], fill_data_o[15:0]}, 64'd0);
    exp_mem.delete();
    exp_fill.delete();
    exp_done = 0;
    exp_clr  = 0;
    repeat (2) @(negedge clk);
    clr = 1'b1;
    check("no_done_after_abort", 64'(done_cnt - d0), 64'd0);
    do_miss(32'h0000_2000, 32'h0, 1'b0, 1'b0, 1'b1);

    check("rd_wr_never_both", {63'b0, both_seen}, 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
